// File: rtl/rng_pkg.sv
// Shared definitions for the TRNG conditioning path: default sizing,
// von Neumann pair encodings and the pair-phase state type.
package rng_pkg;

  localparam int RNG_WORD_W     = 8;
  localparam int RNG_FIFO_DEPTH = 4;
  localparam int RNG_REP_LIMIT  = 32;

  // {first_bit, second_bit} encodings of the two pairs that carry information
  localparam logic [1:0] VN_PAIR_01 = 2'b01;
  localparam logic [1:0] VN_PAIR_10 = 2'b10;

  typedef enum logic {
    PH_FIRST  = 1'b0,
    PH_SECOND = 1'b1
  } vn_phase_e;

endpackage

// File: rtl/rng_conditioner_vn_debiaser.sv
// vn_debiaser: von Neumann pair extractor. Collects raw bits in pairs on
// enabled cycles; a 01 pair yields 0, a 10 pair yields 1, equal pairs are
// discarded. Dropping enabled abandons any half-collected pair.
module vn_debiaser
  import rng_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic enabled,
  input  logic raw_bit,
  output logic bit_valid,
  output logic bit_out
);

  vn_phase_e phase;
  vn_phase_e phase_next;
  logic      first_bit;
  logic      first_bit_next;

  // Pair phase and the stored first bit of the current pair
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase     <= PH_FIRST;
      first_bit <= 1'b0;
    end else begin
      phase     <= phase_next;
      first_bit <= first_bit_next;
    end
  end

  // Next-phase logic; the extracted bit is produced combinationally on the second sample
  always_comb begin
    phase_next     = phase;
    first_bit_next = first_bit;
    bit_valid      = 1'b0;
    bit_out        = 1'b0;
    if (!enabled) begin
      phase_next = PH_FIRST;
    end else begin
      case (phase)
        PH_FIRST: begin
          first_bit_next = raw_bit;
          phase_next     = PH_SECOND;
        end
        PH_SECOND: begin
          phase_next = PH_FIRST;
          case ({first_bit, raw_bit})
            VN_PAIR_01: begin
              bit_valid = 1'b1;
              bit_out   = 1'b0;
            end
            VN_PAIR_10: begin
              bit_valid = 1'b1;
              bit_out   = 1'b1;
            end
            default: begin
              bit_valid = 1'b0;
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: rtl/rng_conditioner.sv
// rng_conditioner: debiases the raw latch-network bit stream, packs the
// unbiased bits LSB-first into WIDTH-bit words and buffers them in a small
// FIFO read through a valid/ready port.
// Optional feature macro: RNG_HEALTH_TEST_EN adds a repetition-count health
// test that flushes the FIFO and blocks output once it trips.
module rng_conditioner
  import rng_pkg::*;
#(
  parameter int WIDTH      = RNG_WORD_W,
  parameter int FIFO_DEPTH = RNG_FIFO_DEPTH,
  parameter int REP_LIMIT  = RNG_REP_LIMIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enabled,
  input  logic             raw_bit,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic             health_fail
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  // Reject sizes the pointer/counter arithmetic cannot handle
  if (WIDTH < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || REP_LIMIT < 2) begin : g_param_check
    $error("rng_conditioner: WIDTH>=2, FIFO_DEPTH power of two >=2, REP_LIMIT>=2 required");
  end

  logic             bit_valid;
  logic             bit_out;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] word_next;
  logic [CNT_W-1:0] cnt;
  logic             word_done;

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             push_ok;
  logic             drop;
  logic             block_push;

  vn_debiaser u_debiaser (
    .clk       (clk),
    .rst_n     (rst_n),
    .enabled   (enabled),
    .raw_bit   (raw_bit),
    .bit_valid (bit_valid),
    .bit_out   (bit_out)
  );

  // Word being assembled with the incoming bit merged in; completes on bit WIDTH-1
  always_comb begin
    word_next      = shreg;
    word_next[cnt] = bit_out;
    word_done      = bit_valid && (cnt == CNT_W'(WIDTH - 1));
  end

  // Packer: partial word is abandoned whenever collection is disabled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (!enabled || word_done) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (bit_valid) begin
      shreg <= word_next;
      cnt   <= cnt + 1'b1;
    end
  end

`ifdef RNG_HEALTH_TEST_EN
  localparam int REP_W = $clog2(REP_LIMIT + 1);

  logic             last_bit;
  logic [REP_W-1:0] rep_cnt;
  logic [REP_W-1:0] rep_next;
  logic             health_trip;
  logic             health_fail_q;

  // Run length including the current sample; saturates at the limit
  always_comb begin
    rep_next = REP_W'(1);
    if (rep_cnt != '0 && raw_bit == last_bit) begin
      rep_next = (rep_cnt == REP_W'(REP_LIMIT)) ? rep_cnt : rep_cnt + 1'b1;
    end
    health_trip = enabled && (rep_next == REP_W'(REP_LIMIT));
  end

  // Repetition counter advances only on enabled cycles; failure flag is sticky
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rep_cnt       <= '0;
      last_bit      <= 1'b0;
      health_fail_q <= 1'b0;
    end else begin
      if (enabled) begin
        rep_cnt  <= rep_next;
        last_bit <= raw_bit;
      end
      if (health_trip) begin
        health_fail_q <= 1'b1;
      end
    end
  end

  assign health_fail = health_fail_q;
  assign block_push  = health_trip || health_fail_q;
`else
  assign health_fail = 1'b0;
  assign block_push  = 1'b0;
`endif

  assign fifo_full  = (occ == OCC_W'(FIFO_DEPTH));
  assign fifo_empty = (occ == '0);
  assign out_valid  = !fifo_empty;
  assign out_data   = fifo_empty ? '0 : mem[rd_ptr];
  assign pop        = out_valid && out_ready && !block_push;
  assign push_ok    = word_done && !block_push && (!fifo_full || pop);
  assign drop       = word_done && !block_push && fifo_full && !pop;

  // FIFO pointers and occupancy; a health trip empties the FIFO
  always_ff @(posedge clk) begin
    if (!rst_n || block_push) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // FIFO storage; contents are only observable through occupancy so no reset needed
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= word_next;
    end
  end

  // Sticky overflow flag for completed words lost to a full FIFO
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rng_conditioner.sv
// Self-checking bench for rng_conditioner: table-driven word assembly plus
// hand-written sequences for overflow, full push/pop, enable drop and the
// optional repetition health test (RNG_HEALTH_TEST_EN).
module tb_rng_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enabled;
  logic       raw_bit;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       overflow;
  logic       health_fail;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    logic       en;
    logic       raw;
    logic       rdy;
    logic       exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl [17];

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  rng_conditioner #(
    .WIDTH      (8),
    .FIFO_DEPTH (4),
    .REP_LIMIT  (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enabled     (enabled),
    .raw_bit     (raw_bit),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overflow    (overflow),
    .health_fail (health_fail)
  );

  // Drive one cycle of inputs, then settle just after the edge
  task automatic applyStimulus(input logic en, input logic raw, input logic rdy);
    enabled   = en;
    raw_bit   = raw;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // One unbiased bit as a von Neumann pair: 1 -> raw 1,0 ; 0 -> raw 0,1
  task automatic send_bit(input logic b, input logic rdy);
    applyStimulus(1'b1, b, rdy);
    applyStimulus(1'b1, ~b, rdy);
  endtask

  task automatic send_word(input logic [7:0] w, input logic rdy);
    for (int i = 0; i < 8; i++) send_bit(w[i], rdy);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  // Watchdog so the run always terminates
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] pat;
    logic       seen;
    logic [7:0] exp_words [4];

    pat = 4'b0110;
    for (int i = 0; i < 16; i++) begin
      tbl[i].en        = 1'b1;
      tbl[i].raw       = pat[i % 4];
      tbl[i].rdy       = 1'b1;
      tbl[i].exp_valid = (i == 15);
      tbl[i].exp_data  = 8'hAA;
    end
    tbl[16].en        = 1'b0;
    tbl[16].raw       = 1'b0;
    tbl[16].rdy       = 1'b1;
    tbl[16].exp_valid = 1'b0;
    tbl[16].exp_data  = 8'h00;

    // Reset held for two cycles
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_data", 32'(out_data), 32'd0);
    checkOutput("reset overflow", 32'(overflow), 32'd0);
    checkOutput("reset health_fail", 32'(health_fail), 32'd0);
    rst_n = 1'b1;

    // Repeating 0,1,1,0 builds a single 8'hAA visible for exactly one cycle
    for (int i = 0; i < 17; i++) begin
      applyStimulus(tbl[i].en, tbl[i].raw, tbl[i].rdy);
      checkOutput($sformatf("aa valid row %0d", i), 32'(out_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) checkOutput($sformatf("aa data row %0d", i), 32'(out_data), 32'(tbl[i].exp_data));
    end

    // Only 00/11 pairs: nothing may ever be emitted
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'b1, (i % 4) >= 2, 1'b1);
      seen = seen | out_valid;
    end
    checkOutput("equal pairs valid seen", 32'(seen), 32'd0);
    checkOutput("equal pairs overflow", 32'(overflow), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Five words into a depth-4 FIFO with no consumer
    exp_words[0] = 8'h11; exp_words[1] = 8'h22; exp_words[2] = 8'h33; exp_words[3] = 8'h44;
    for (int i = 0; i < 4; i++) send_word(exp_words[i], 1'b0);
    checkOutput("fill overflow before 5th", 32'(overflow), 32'd0);
    checkOutput("fill valid", 32'(out_valid), 32'd1);
    send_word(8'h55, 1'b0);
    checkOutput("overflow after 5th", 32'(overflow), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("head held while stalled", 32'(out_data), 32'h11);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("drain valid %0d", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("drain data %0d", i), 32'(out_data), 32'(exp_words[i]));
      applyStimulus(1'b0, 1'b0, 1'b1);
    end
    checkOutput("drain empty", 32'(out_valid), 32'd0);
    checkOutput("overflow sticky", 32'(overflow), 32'd1);

    // Push and pop on the same edge while full: both succeed
    do_reset();
    for (int i = 0; i < 4; i++) send_word(exp_words[i], 1'b0);
    for (int i = 0; i < 7; i++) send_bit(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("full push+pop overflow", 32'(overflow), 32'd0);
    checkOutput("full push+pop head", 32'(out_data), 32'h22);
    exp_words[0] = 8'h22; exp_words[1] = 8'h33; exp_words[2] = 8'h44; exp_words[3] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("full drain valid %0d", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("full drain data %0d", i), 32'(out_data), 32'(exp_words[i]));
      applyStimulus(1'b0, 1'b0, 1'b1);
    end
    checkOutput("full drain empty", 32'(out_valid), 32'd0);

    // Enable drop after 7 bits plus a half pair discards the partial word
    do_reset();
    for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("enable drop no word", 32'(out_valid), 32'd0);
    send_word(8'h5A, 1'b0);
    checkOutput("resume valid", 32'(out_valid), 32'd1);
    checkOutput("resume data", 32'(out_data), 32'h5A);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("resume single word", 32'(out_valid), 32'd0);

    // Stuck-at-1 raw stream for 32 enabled cycles
    do_reset();
    send_word(8'h3C, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("stuck pre valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 31; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("stuck 31 health", 32'(health_fail), 32'd0);
    checkOutput("stuck 31 valid", 32'(out_valid), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0);
`ifdef RNG_HEALTH_TEST_EN
    checkOutput("stuck 32 health", 32'(health_fail), 32'd1);
    checkOutput("stuck 32 valid", 32'(out_valid), 32'd0);
    send_word(8'hA5, 1'b0);
    checkOutput("blocked push valid", 32'(out_valid), 32'd0);
    checkOutput("health sticky", 32'(health_fail), 32'd1);
`else
    checkOutput("stuck 32 health", 32'(health_fail), 32'd0);
    checkOutput("stuck 32 valid", 32'(out_valid), 32'd1);
    send_word(8'hA5, 1'b0);
    checkOutput("no test head kept", 32'(out_data), 32'h3C);
    checkOutput("no test health", 32'(health_fail), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
